rob_wb_arbiter: RTL and testbench

Writeback arbiter between the execution units and the reorder buffer's store interface. Each execution unit hands over one completed result (ROB slot index plus `T` entry) through a valid/ready handshake. The arbiter buffers one result per unit and each cycle grants up to `WR_COUNT` buffered results, in round-robin order, onto the ROB write ports. It owns no ROB state; it only shares the fixed set of ROB write ports fairly among `NUM_EU` producers.

---
 rtl/rob_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rob_wb_arbiter
//  Description : Writeback arbiter. Buffers one completed result per
//                execution unit and grants up to WR_COUNT of them per cycle,
//                in round-robin order, onto registered ROB write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_wb_arbiter #(
    parameter type T         = logic [31:0],
    parameter int  NUM_EU    = 6,
    parameter int  WR_COUNT  = 4,
    parameter int  DEPTH     = 16,
    parameter int  DEPTHLOG2 = $clog2(DEPTH),
    parameter int  EULOG2    = $clog2(NUM_EU),
    parameter int  CNTW      = $clog2(NUM_EU + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 eu_valid    [NUM_EU],
    input  logic [DEPTHLOG2-1:0] eu_slot     [NUM_EU],
    input  T                     eu_data     [NUM_EU],
    output logic                 eu_ready    [NUM_EU],
    output logic                 write_valid [WR_COUNT],
    output logic [DEPTHLOG2-1:0] write_slot  [WR_COUNT],
    output T                     write_data  [WR_COUNT],
    output logic [CNTW-1:0]      pending_count,
    output logic                 idle
);

    // A single-unit build still needs a 1-bit pointer to hold index 0.
    localparam int c_PTRW = (EULOG2 > 0) ? EULOG2 : 1;

    logic [NUM_EU-1:0]    r_hold_v;
    logic [DEPTHLOG2-1:0] r_hold_slot [NUM_EU];
    T                     r_hold_data [NUM_EU];
    logic [c_PTRW-1:0]    r_rr_ptr;

    logic [NUM_EU-1:0]    w_grant;
    logic [c_PTRW-1:0]    w_port_src [WR_COUNT];
    logic [c_PTRW-1:0]    w_last;
    logic [c_PTRW-1:0]    w_rr_next;
    int                   w_gcnt;
    logic [CNTW-1:0]      w_pop;
    logic                 w_any_wv;

    // Unit index visited at scan step k; ptr is always below NUM_EU.
    function automatic int f_idx(input logic [c_PTRW-1:0] ptr, input int k);
        return (int'(ptr) + k) % NUM_EU;
    endfunction

    // Round-robin scan: first WR_COUNT occupied holders win, in scan order.
    always_comb begin
        w_grant = '0;
        w_gcnt  = 0;
        w_last  = r_rr_ptr;
        for (int p = 0; p < WR_COUNT; p++) begin
            w_port_src[p] = '0;
        end
        for (int k = 0; k < NUM_EU; k++) begin
            if (r_hold_v[f_idx(r_rr_ptr, k)] && (w_gcnt < WR_COUNT)) begin
                w_grant[f_idx(r_rr_ptr, k)] = 1'b1;
                w_port_src[w_gcnt]          = c_PTRW'(f_idx(r_rr_ptr, k));
                w_last                      = c_PTRW'(f_idx(r_rr_ptr, k));
                w_gcnt                      = w_gcnt + 1;
            end
        end
    end

    // Pointer resumes just past the last winner, wrapping at NUM_EU.
    assign w_rr_next = (int'(w_last) + 1 == NUM_EU) ? '0 : w_last + c_PTRW'(1);

    // Ready depends only on state and grant so it never waits on eu_valid.
    generate
        for (genvar i = 0; i < NUM_EU; i++) begin : g_ready
            assign eu_ready[i] = ~reset & (~r_hold_v[i] | w_grant[i]);
        end
    endgenerate

    // Holding registers: a reload on a granted cycle replaces the old result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_v <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < NUM_EU; i++) begin
                r_hold_slot[i] <= '0;
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EU; i++) begin
                if (eu_valid[i] && eu_ready[i]) begin
                    r_hold_v[i]    <= 1'b1;
                    r_hold_slot[i] <= eu_slot[i];
                    r_hold_data[i] <= eu_data[i];
                end else if (w_grant[i]) begin
                    r_hold_v[i] <= 1'b0;
                end
            end
            if (w_gcnt > 0) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Registered write ports; inactive ports drive zero payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < WR_COUNT; p++) begin
                write_valid[p] <= 1'b0;
                write_slot[p]  <= '0;
                write_data[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < WR_COUNT; p++) begin
                write_valid[p] <= (w_gcnt > p);
                if (w_gcnt > p) begin
                    write_slot[p] <= r_hold_slot[w_port_src[p]];
                    write_data[p] <= r_hold_data[w_port_src[p]];
                end else begin
                    write_slot[p] <= '0;
                    write_data[p] <= '0;
                end
            end
        end
    end

    // Occupancy count and any-port-active summary.
    always_comb begin
        w_pop    = '0;
        w_any_wv = 1'b0;
        for (int i = 0; i < NUM_EU; i++) begin
            w_pop = w_pop + CNTW'(r_hold_v[i]);
        end
        for (int p = 0; p < WR_COUNT; p++) begin
            w_any_wv = w_any_wv | write_valid[p];
        end
    end

    assign pending_count = reset ? '0 : w_pop;
    assign idle          = reset | ((r_hold_v == '0) & ~w_any_wv);

`ifndef SYNTHESIS
    // Two active ports carrying the same slot means upstream sent a duplicate.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int p = 0; p < WR_COUNT; p++) begin
                for (int q = p + 1; q < WR_COUNT; q++) begin
                    assert (!(write_valid[p] && write_valid[q] &&
                              (write_slot[p] == write_slot[q])))
                    else $error("rob_wb_arbiter: duplicate slot on ports %0d/%0d", p, q);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_wb_arbiter
//  Description : Self-checking bench for rob_wb_arbiter (6 units, 4 ports).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_wb_arbiter;

    localparam int c_N = 6;
    localparam int c_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        eu_valid    [c_N];
    logic [3:0]  eu_slot     [c_N];
    logic [31:0] eu_data     [c_N];
    logic        eu_ready    [c_N];
    logic        write_valid [c_W];
    logic [3:0]  write_slot  [c_W];
    logic [31:0] write_data  [c_W];
    logic [2:0]  pending_count;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    rob_wb_arbiter #(
        .T        (logic [31:0]),
        .NUM_EU   (c_N),
        .WR_COUNT (c_W),
        .DEPTH    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .eu_valid      (eu_valid),
        .eu_slot       (eu_slot),
        .eu_data       (eu_data),
        .eu_ready      (eu_ready),
        .write_valid   (write_valid),
        .write_slot    (write_slot),
        .write_data    (write_data),
        .pending_count (pending_count),
        .idle          (idle)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic [5:0]  v;
        logic [5:0]  ready;
        logic [3:0]  wv;
        logic [11:0] src;    // 3 bits per port: source unit index
        logic [2:0]  pend;
        logic        idle;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] slot_of(input int i);
        return 4'(2 * i + 1);
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    function automatic logic [5:0] ready_vec();
        logic [5:0] r;
        for (int i = 0; i < c_N; i++) r[i] = eu_ready[i];
        return r;
    endfunction

    function automatic logic [3:0] wv_vec();
        logic [3:0] r;
        for (int p = 0; p < c_W; p++) r[p] = write_valid[p];
        return r;
    endfunction

    task automatic set_valid(input logic [5:0] m);
        for (int i = 0; i < c_N; i++) begin
            eu_valid[i] = m[i];
            eu_slot[i]  = slot_of(i);
            eu_data[i]  = data_of(i);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_port(input string name, input int p, input int src);
        chk({name, "_slot"}, 32'(write_slot[p]), 32'(slot_of(src)));
        chk({name, "_data"}, write_data[p], data_of(src));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_valid(6'h00);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] src;
        int groups [3][4];

        //            rst v        ready     wv       src      pend idle
        tbl[0]  = '{1'b1, 6'h00, 6'h00, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[1]  = '{1'b0, 6'h04, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[2]  = '{1'b0, 6'h00, 6'h3f, 4'h0, 12'h000, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 6'h00, 6'h3f, 4'h1, 12'h002, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 6'h00, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[5]  = '{1'b1, 6'h00, 6'h00, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[6]  = '{1'b0, 6'h3f, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[7]  = '{1'b0, 6'h00, 6'h0f, 4'h0, 12'h000, 3'd6, 1'b0};
        tbl[8]  = '{1'b0, 6'h00, 6'h3f, 4'hf, 12'h688, 3'd2, 1'b0};
        tbl[9]  = '{1'b0, 6'h00, 6'h3f, 4'h3, 12'h02c, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 6'h00, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[11] = '{1'b0, 6'h07, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[12] = '{1'b1, 6'h00, 6'h00, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[13] = '{1'b0, 6'h00, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};
        tbl[14] = '{1'b0, 6'h00, 6'h3f, 4'h0, 12'h000, 3'd0, 1'b1};

        groups = '{'{0, 1, 2, 3}, '{4, 5, 0, 1}, '{2, 3, 4, 5}};

        reset = 1'b1;
        set_valid(6'h00);
        step();
        step();

        // Table: single request, burst, mid-stream reset
        for (int r = 0; r < 15; r++) begin
            reset = tbl[r].rst;
            set_valid(tbl[r].v);
            #1;
            chk($sformatf("t%0d_ready", r), 32'(ready_vec()), 32'(tbl[r].ready));
            chk($sformatf("t%0d_wv", r), 32'(wv_vec()), 32'(tbl[r].wv));
            chk($sformatf("t%0d_pend", r), 32'(pending_count), 32'(tbl[r].pend));
            chk($sformatf("t%0d_idle", r), 32'(idle), 32'(tbl[r].idle));
            for (int p = 0; p < c_W; p++) begin
                src = tbl[r].src[3*p +: 3];
                chk($sformatf("t%0d_p%0d_slot", r, p), 32'(write_slot[p]),
                    tbl[r].wv[p] ? 32'(slot_of(int'(src))) : 32'h0);
                chk($sformatf("t%0d_p%0d_data", r, p), write_data[p],
                    tbl[r].wv[p] ? data_of(int'(src)) : 32'h0);
            end
            step();
        end

        // Saturation: all units valid every cycle
        do_reset();
        set_valid(6'h3f);
        for (int c = 0; c < 11; c++) begin
            #1;
            if (c < 2) begin
                chk($sformatf("sat%0d_wv", c), 32'(wv_vec()), 32'h0);
            end else begin
                chk($sformatf("sat%0d_wv", c), 32'(wv_vec()), 32'hf);
                for (int p = 0; p < c_W; p++) begin
                    chk_port($sformatf("sat%0d_p%0d", c, p), p, groups[(c - 2) % 3][p]);
                end
            end
            step();
        end

        // Streaming: EU1 every cycle, slots wrap through 0..15
        do_reset();
        set_valid(6'h00);
        for (int n = 0; n < 22; n++) begin
            eu_valid[1] = 1'b1;
            eu_slot[1]  = 4'(n % 16);
            eu_data[1]  = 32'h5000 + 32'(n);
            #1;
            chk($sformatf("str%0d_ready1", n), 32'(eu_ready[1]), 32'h1);
            if (n >= 2) begin
                chk($sformatf("str%0d_wv", n), 32'(wv_vec()), 32'h1);
                chk($sformatf("str%0d_slot", n), 32'(write_slot[0]), 32'((n - 2) % 16));
                chk($sformatf("str%0d_data", n), write_data[0], 32'h5000 + 32'(n - 2));
            end else begin
                chk($sformatf("str%0d_wv", n), 32'(wv_vec()), 32'h0);
            end
            step();
        end

        // Backpressure: EU4 blocked, then accepted while granted
        do_reset();
        set_valid(6'h00);
        for (int i = 0; i < 5; i++) begin
            eu_valid[i] = 1'b1;
            eu_slot[i]  = 4'(i + 1);
            eu_data[i]  = 32'hA000 + 32'(i);
        end
        #1;
        chk("bp0_ready", 32'(ready_vec()), 32'h3f);
        step();
        eu_slot[0] = 4'd10; eu_data[0] = 32'hB000;
        eu_valid[1] = 1'b0; eu_valid[2] = 1'b0; eu_valid[3] = 1'b0;
        eu_slot[4] = 4'd12; eu_data[4] = 32'hB004;
        #1;
        chk("bp1_ready", 32'(ready_vec()), 32'h2f);
        step();
        eu_valid[0] = 1'b0;
        #1;
        chk("bp2_ready", 32'(ready_vec()), 32'h3f);
        chk("bp2_wv", 32'(wv_vec()), 32'hf);
        for (int p = 0; p < c_W; p++) begin
            chk($sformatf("bp2_p%0d_slot", p), 32'(write_slot[p]), 32'(p + 1));
            chk($sformatf("bp2_p%0d_data", p), write_data[p], 32'hA000 + 32'(p));
        end
        step();
        eu_valid[4] = 1'b0;
        #1;
        chk("bp3_wv", 32'(wv_vec()), 32'h3);
        chk("bp3_p0_slot", 32'(write_slot[0]), 32'd5);
        chk("bp3_p0_data", write_data[0], 32'hA004);
        chk("bp3_p1_slot", 32'(write_slot[1]), 32'd10);
        chk("bp3_p1_data", write_data[1], 32'hB000);
        chk("bp3_pend", 32'(pending_count), 32'd1);
        step();
        #1;
        chk("bp4_wv", 32'(wv_vec()), 32'h1);
        chk("bp4_p0_slot", 32'(write_slot[0]), 32'd12);
        chk("bp4_p0_data", write_data[0], 32'hB004);
        step();
        #1;
        chk("bp5_wv", 32'(wv_vec()), 32'h0);
        chk("bp5_idle", 32'(idle), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
